// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if
//   Groups the control/status signals of the program sequencer.
//   Start/Abort      : sequence control from the top-level start logic
//   Halt             : halt flag returned by the fetch stage
//   Init/ProgState   : fetch-stage Init and program index
//   Busy/Done        : sequencer status
//   CycleCount/CountValid : per-program RUN cycle count and its update pulse
//   Timeout          : sticky watchdog flag (always 0 unless PROG_WATCHDOG_EN)
// Modports:
//   master : the sequencer itself (drives Init/ProgState and status)
//   slave  : the surrounding logic (drives Start/Abort/Halt)
interface prog_sequencer_if;
    logic        Start;
    logic        Abort;
    logic        Halt;
    logic        Init;
    logic [1:0]  ProgState;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;
    logic        CountValid;
    logic        Timeout;

    modport master (
        input  Start, Abort, Halt,
        output Init, ProgState, Busy, Done, CycleCount, CountValid, Timeout
    );

    modport slave (
        output Start, Abort, Halt,
        input  Init, ProgState, Busy, Done, CycleCount, CountValid, Timeout
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Upstream controller for the instruction-fetch stage. On Start it runs
//   programs 0..NUM_PROGS-1 back to back: each is held in Init for
//   INIT_CYCLES cycles, released, and run until the fetch stage raises Halt.
//   The RUN-cycle count of each program is reported on CycleCount with a
//   one-cycle CountValid pulse; after the last program Done is raised.
// Ports:
//   CLK   : clock, all state changes on posedge
//   Reset : synchronous, active-high reset
//   bus   : prog_sequencer_if.master (Start, Abort, Halt in;
//           Init, ProgState, Busy, Done, CycleCount, CountValid, Timeout out)
// Build option:
//   PROG_WATCHDOG_EN : when defined, a program whose RUN count reaches
//   WDOG_LIMIT without a qualified Halt is aborted and Timeout is set
//   (sticky until the next Start or Reset). When undefined Timeout is 0.
module prog_sequencer #(
    parameter int unsigned NUM_PROGS   = 3,
    parameter int unsigned INIT_CYCLES = 2
`ifdef PROG_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_LIMIT  = 1000
`endif
) (
    input logic              CLK,
    input logic              Reset,
    prog_sequencer_if.master bus
);

    localparam int unsigned INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [1:0]        LAST_IDX  = 2'(NUM_PROGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [15:0]         run_cnt_q, run_cnt_d;
    logic [15:0]         cycle_count_q, cycle_count_d;
    logic                count_valid_q, count_valid_d;
    logic                init_q, init_d;
    logic [1:0]          prog_state_q, prog_state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                halt_qual;
`ifdef PROG_WATCHDOG_EN
    logic                timeout_q, timeout_d;
    logic                wdog_hit;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        init_cnt_d    = init_cnt_q;
        run_cnt_d     = run_cnt_q;
        cycle_count_d = cycle_count_q;
        count_valid_d = 1'b0;
        halt_qual     = 1'b0;
`ifdef PROG_WATCHDOG_EN
        timeout_d     = timeout_q;
        wdog_hit      = 1'b0;
`endif

        if (bus.Abort) begin
            // CycleCount and Timeout deliberately keep their values.
            state_d    = S_IDLE;
            idx_d      = '0;
            init_cnt_d = '0;
            run_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.Start) begin
                        state_d    = S_INIT;
                        idx_d      = '0;
                        init_cnt_d = '0;
`ifdef PROG_WATCHDOG_EN
                        timeout_d  = 1'b0;
`endif
                    end
                end

                S_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d   = S_RUN;
                        run_cnt_d = '0;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end

                S_RUN: begin
                    // The fetch stage keeps Halt from the previous program
                    // until it leaves Init, so Halt seen at run_cnt == 0 is stale.
                    halt_qual = bus.Halt && (run_cnt_q != '0);
`ifdef PROG_WATCHDOG_EN
                    wdog_hit  = !halt_qual && ({16'd0, run_cnt_q} == WDOG_LIMIT);
                    if (halt_qual || wdog_hit) begin
                        if (wdog_hit) begin
                            timeout_d = 1'b1;
                        end
`else
                    if (halt_qual) begin
`endif
                        // On a watchdog hit run_cnt equals WDOG_LIMIT here.
                        cycle_count_d = run_cnt_q;
                        count_valid_d = 1'b1;
                        init_cnt_d    = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = S_INIT;
                        end
                    end else if (run_cnt_q != '1) begin
                        run_cnt_d = run_cnt_q + 16'd1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        // Outputs are registered copies of what the next state implies.
        init_d       = (state_d != S_RUN);
        busy_d       = (state_d == S_INIT) || (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
        prog_state_d = busy_d ? idx_d : '0;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            init_cnt_q    <= '0;
            run_cnt_q     <= '0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
            init_q        <= 1'b1;
            prog_state_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef PROG_WATCHDOG_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            init_cnt_q    <= init_cnt_d;
            run_cnt_q     <= run_cnt_d;
            cycle_count_q <= cycle_count_d;
            count_valid_q <= count_valid_d;
            init_q        <= init_d;
            prog_state_q  <= prog_state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef PROG_WATCHDOG_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign bus.Init       = init_q;
    assign bus.ProgState  = prog_state_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.CycleCount = cycle_count_q;
    assign bus.CountValid = count_valid_q;
`ifdef PROG_WATCHDOG_EN
    assign bus.Timeout    = timeout_q;
`else
    assign bus.Timeout    = 1'b0;
`endif

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Upstream controller for the instruction-fetch stage. Drives the fetch stage's Init and ProgState inputs and watches its Halt output.
- On a Start pulse it runs programs 0..NUM_PROGS-1 back to back. Each program is held in init for INIT_CYCLES cycles, released, and run until Halt.
- Reports a per-program cycle count, then raises Done.
- Sits between the top-level testbench/start logic and the fetch stage.

Parameters:
- NUM_PROGS, 3, number of programs run per Start; legal range 1..4 (ProgState is 2 bits).
- INIT_CYCLES, 2, cycles Init is held high before each program; legal range ≥1.
- WDOG_LIMIT, 1000, RUN-cycle limit per program; used only with PROG_WATCHDOG_EN.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin a sequence; sampled only in IDLE or DONE.
- Abort  input  1  return to IDLE next edge from any state.
- Halt  input  1  Halt flag from fetch stage.
- Init  output  1  to fetch stage Init; 1 = hold/preset PC.
- ProgState  output  2  to fetch stage ProgState; current program index.
- Busy  output  1  high in INIT and RUN.
- Done  output  1  high in DONE.
- CycleCount  output  16  RUN cycles of the last completed program.
- CountValid  output  1  one-cycle pulse when CycleCount updates.
- Timeout  output  1  sticky watchdog flag; tied 0 without PROG_WATCHDOG_EN.

Behaviour:
- All outputs are registered. Reset (sync, highest priority) → IDLE, Init=1, ProgState=0, Busy=0, Done=0, CycleCount=0, CountValid=0, Timeout=0, idx=0.
- Abort (next priority) → IDLE with the same values as reset, except CycleCount and Timeout are held.
- States: IDLE, INIT, RUN, DONE.
- IDLE/DONE: Init=1, ProgState=0. If Start=1 → INIT with idx=0, Done=0, Timeout=0. DONE holds Done=1 until Start, Abort or Reset.
- INIT: Init=1, ProgState=idx. Stays exactly INIT_CYCLES cycles, then → RUN.
- RUN: Init=0, ProgState=idx. run_cnt clears to 0 on entry and increments each RUN cycle, saturating at 16'hFFFF.
- Halt qualification: Halt is ignored while run_cnt=0. The fetch stage does not clear Halt while Init is high, so a stale Halt from the previous program is still present in the first RUN cycle.
- Halt=1 with run_cnt=k≥1, on the next edge:
  - CycleCount<=k; CountValid=1 for that one cycle.
  - If idx==NUM_PROGS-1 → DONE; else idx++ and → INIT.
- Start while Busy is ignored. Start and Halt in the same cycle: Halt is processed and Start is ignored.
- CountValid is 0 in every cycle other than the completion pulse.

Optional Feature:
- Macro PROG_WATCHDOG_EN.
- Defined: in RUN, if run_cnt reaches WDOG_LIMIT without a qualified Halt, the program is aborted.
  - CycleCount<=WDOG_LIMIT, CountValid pulses, Timeout<=1 (sticky until next Start or Reset).
  - The sequencer advances exactly as on Halt.
  - A qualified Halt in the same cycle wins; Timeout stays 0.
- Undefined: no watchdog logic; Timeout tied 0; RUN waits indefinitely for Halt.

Test Plan:
- Reset held 2 cycles, then released with Start=0 → Init=1, ProgState=0, Busy=0, Done=0, CountValid=0 indefinitely.
- Start pulse, NUM_PROGS=2, INIT_CYCLES=2, real fetch stage → Init high 2 cycles, ProgState=0, then RUN.
  - Program 0: Halt after PC 44 → CycleCount=45 with CountValid pulse.
  - Program 1: ProgState=1, PC starts at 45, Halt after PC 103 → CycleCount=59, then Done=1, Init=1.
- Halt held 1 through INIT into the first RUN cycle → ignored; the program runs until a fresh Halt at run_cnt=5 → CycleCount=5.
- Abort asserted mid-RUN of program 1 → next edge IDLE, Init=1, Busy=0, ProgState=0; a later Start restarts at program 0.
- Start pulsed during RUN and again coincident with a final Halt → both ignored, sequence unchanged; a Start in DONE restarts and clears Done.
- With PROG_WATCHDOG_EN and WDOG_LIMIT=10, Halt never asserted → CycleCount=10, Timeout=1, and the sequencer advances to the next program.
